ifft8: RTL and testbench



---
 rtl/ifft8_pkg.sv | 29 ++
 rtl/ifft8_twiddle_mult.sv | 60 ++++++
 rtl/ifft8.sv | 228 ++++++++++++++++++++++
 tb/tb_ifft8.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft8_pkg.sv
// ifft8_pkg: shared widths, types, states and helpers
// for the 8-point inverse FFT datapath.
package ifft8_pkg;
    localparam int DATA_W  = 32;
    localparam int GUARD_W = 3;
    localparam int TW_W    = 16;
    localparam int INT_W   = DATA_W + GUARD_W;

    localparam logic signed [TW_W-1:0] TW_C = 16'sh5A82;

    typedef logic signed [INT_W-1:0] int_t;
    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t S1   = 3'd1;
    localparam state_t TW_A = 3'd2;
    localparam state_t TW_B = 3'd3;
    localparam state_t S2   = 3'd4;
    localparam state_t S3   = 3'd5;
    localparam state_t DONE = 3'd6;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    function automatic int_t sext(input logic [DATA_W-1:0] v);
        return {{GUARD_W{v[DATA_W-1]}}, v};
    endfunction
endpackage

// File: rtl/ifft8_twiddle_mult.sv
// ifft8_twiddle_mult: 2-stage complex multiply by W1 or W3,
// both of which are c*(+-1 - j) with c = TW_C in Q1.15.
module ifft8_twiddle_mult
    import ifft8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel_w3_i,
    input  int_t       re_i,
    input  int_t       im_i,
    output int_t       re_o,
    output int_t       im_o
);
    localparam int SUM_W  = INT_W + 1;
    localparam int PROD_W = SUM_W + TW_W;

    logic signed [SUM_W-1:0]  s;
    logic signed [SUM_W-1:0]  t;
    logic signed [PROD_W-1:0] ps;
    logic signed [PROD_W-1:0] pt;
    logic signed [PROD_W-1:0] p_re_d, p_re_q;
    logic signed [PROD_W-1:0] p_im_d, p_im_q;
    int_t                     re_d, re_q;
    int_t                     im_d, im_q;

    assign s  = SUM_W'(re_i) + SUM_W'(im_i);
    assign t  = SUM_W'(im_i) - SUM_W'(re_i);
    assign ps = PROD_W'(s) * PROD_W'(TW_C);
    assign pt = PROD_W'(t) * PROD_W'(TW_C);

    // W1: c*s + j*c*t   W3: c*t - j*c*s
    always_comb begin
        p_re_d = ps;
        p_im_d = pt;
        if (sel_w3_i) begin
            p_re_d = pt;
            p_im_d = -ps;
        end
    end

    assign re_d = INT_W'(p_re_q >>> (TW_W - 1));
    assign im_d = INT_W'(p_im_q >>> (TW_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_re_q <= '0;
            p_im_q <= '0;
            re_q   <= '0;
            im_q   <= '0;
        end else begin
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
            re_q   <= re_d;
            im_q   <= im_d;
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;
endmodule

// File: rtl/ifft8.sv
// ifft8: 8-point inverse DFT as conj -> radix-2 DIF FFT -> conj
// -> >>>3, sequenced by a small FSM with valid/ready on both ends.
module ifft8
    import ifft8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] X0_real,
    input  logic [DATA_W-1:0] X1_real,
    input  logic [DATA_W-1:0] X2_real,
    input  logic [DATA_W-1:0] X3_real,
    input  logic [DATA_W-1:0] X4_real,
    input  logic [DATA_W-1:0] X5_real,
    input  logic [DATA_W-1:0] X6_real,
    input  logic [DATA_W-1:0] X7_real,
    input  logic [DATA_W-1:0] X0_imag,
    input  logic [DATA_W-1:0] X1_imag,
    input  logic [DATA_W-1:0] X2_imag,
    input  logic [DATA_W-1:0] X3_imag,
    input  logic [DATA_W-1:0] X4_imag,
    input  logic [DATA_W-1:0] X5_imag,
    input  logic [DATA_W-1:0] X6_imag,
    input  logic [DATA_W-1:0] X7_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x0_real,
    output logic [DATA_W-1:0] x1_real,
    output logic [DATA_W-1:0] x2_real,
    output logic [DATA_W-1:0] x3_real,
    output logic [DATA_W-1:0] x4_real,
    output logic [DATA_W-1:0] x5_real,
    output logic [DATA_W-1:0] x6_real,
    output logic [DATA_W-1:0] x7_real,
    output logic [DATA_W-1:0] x0_imag,
    output logic [DATA_W-1:0] x1_imag,
    output logic [DATA_W-1:0] x2_imag,
    output logic [DATA_W-1:0] x3_imag,
    output logic [DATA_W-1:0] x4_imag,
    output logic [DATA_W-1:0] x5_imag,
    output logic [DATA_W-1:0] x6_imag,
    output logic [DATA_W-1:0] x7_imag,
    output logic              busy
);
    logic [DATA_W-1:0] xin_re [8];
    logic [DATA_W-1:0] xin_im [8];

    state_t            state_d, state_q;
    logic              ov_d, ov_q;
    int_t              re_d [8];
    int_t              re_q [8];
    int_t              im_d [8];
    int_t              im_q [8];
    int_t              a_re [8];
    int_t              a_im [8];
    logic [DATA_W-1:0] xr_d [8];
    logic [DATA_W-1:0] xr_q [8];
    logic [DATA_W-1:0] xi_d [8];
    logic [DATA_W-1:0] xi_q [8];

    int_t              m1_re, m1_im;
    int_t              m3_re, m3_im;

    assign xin_re[0] = X0_real;
    assign xin_re[1] = X1_real;
    assign xin_re[2] = X2_real;
    assign xin_re[3] = X3_real;
    assign xin_re[4] = X4_real;
    assign xin_re[5] = X5_real;
    assign xin_re[6] = X6_real;
    assign xin_re[7] = X7_real;
    assign xin_im[0] = X0_imag;
    assign xin_im[1] = X1_imag;
    assign xin_im[2] = X2_imag;
    assign xin_im[3] = X3_imag;
    assign xin_im[4] = X4_imag;
    assign xin_im[5] = X5_imag;
    assign xin_im[6] = X6_imag;
    assign xin_im[7] = X7_imag;

    // d[1] and d[3] sit in slots 5 and 7 after S1
    ifft8_twiddle_mult u_tw1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_w3_i (1'b0),
        .re_i     (re_q[5]),
        .im_i     (im_q[5]),
        .re_o     (m1_re),
        .im_o     (m1_im)
    );

    ifft8_twiddle_mult u_tw3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_w3_i (1'b1),
        .re_i     (re_q[7]),
        .im_i     (im_q[7]),
        .re_o     (m3_re),
        .im_o     (m3_im)
    );

    always_comb begin
        a_re = re_q;
        a_im = im_q;
        a_re[5] = m1_re;
        a_im[5] = m1_im;
        a_re[7] = m3_re;
        a_im[7] = m3_im;
    end

    always_comb begin
        state_d = state_q;
        ov_d    = ov_q;
        re_d    = re_q;
        im_d    = im_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < 8; k++) begin
                        re_d[k] = sext(xin_re[k]);
                        im_d[k] = -sext(xin_im[k]);
                    end
                    state_d = S1;
                end
            end
            S1: begin
                for (int k = 0; k < 4; k++) begin
                    re_d[k]   = re_q[k] + re_q[k+4];
                    im_d[k]   = im_q[k] + im_q[k+4];
                    re_d[k+4] = re_q[k] - re_q[k+4];
                    im_d[k+4] = im_q[k] - im_q[k+4];
                end
                state_d = TW_A;
            end
            TW_A: begin
                // W2 = -j is an exact swap/negate
                re_d[6] = im_q[6];
                im_d[6] = -re_q[6];
                state_d = TW_B;
            end
            TW_B: begin
                state_d = S2;
            end
            S2: begin
                for (int h = 0; h < 8; h += 4) begin
                    re_d[h]   = a_re[h] + a_re[h+2];
                    im_d[h]   = a_im[h] + a_im[h+2];
                    re_d[h+1] = a_re[h+1] + a_re[h+3];
                    im_d[h+1] = a_im[h+1] + a_im[h+3];
                    re_d[h+2] = a_re[h] - a_re[h+2];
                    im_d[h+2] = a_im[h] - a_im[h+2];
                    re_d[h+3] = a_im[h+1] - a_im[h+3];
                    im_d[h+3] = a_re[h+3] - a_re[h+1];
                end
                state_d = S3;
            end
            S3: begin
                for (int m = 0; m < 8; m += 2) begin
                    re_d[m]   = re_q[m] + re_q[m+1];
                    im_d[m]   = im_q[m] + im_q[m+1];
                    re_d[m+1] = re_q[m] - re_q[m+1];
                    im_d[m+1] = im_q[m] - im_q[m+1];
                end
                state_d = DONE;
            end
            DONE: begin
                if (!ov_q) begin
                    for (int n = 0; n < 8; n++) begin
                        xr_d[n] = DATA_W'(re_q[bitrev3(3'(n))] >>> 3);
                        xi_d[n] = DATA_W'((-im_q[bitrev3(3'(n))]) >>> 3);
                    end
                    ov_d = 1'b1;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
                xr_q[k] <= '0;
                xi_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ov_q    <= ov_d;
            re_q    <= re_d;
            im_q    <= im_d;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;

    assign x0_real = xr_q[0];
    assign x1_real = xr_q[1];
    assign x2_real = xr_q[2];
    assign x3_real = xr_q[3];
    assign x4_real = xr_q[4];
    assign x5_real = xr_q[5];
    assign x6_real = xr_q[6];
    assign x7_real = xr_q[7];
    assign x0_imag = xi_q[0];
    assign x1_imag = xi_q[1];
    assign x2_imag = xi_q[2];
    assign x3_imag = xi_q[3];
    assign x4_imag = xi_q[4];
    assign x5_imag = xi_q[5];
    assign x6_imag = xi_q[6];
    assign x7_imag = xi_q[7];
endmodule

// File: tb/tb_ifft8.sv
// tb_ifft8: table vectors, backpressure/reset sequences and
// random frames checked against a direct inverse-DFT model.
module tb_ifft8;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [31:0] Xr [8];
    logic [31:0] Xi [8];
    logic [31:0] xr [8];
    logic [31:0] xi [8];

    int checks   = 0;
    int failures = 0;

    real mr [8];
    real mi [8];

    typedef struct packed {
        logic [7:0][31:0] in_re;
        logic [7:0][31:0] in_im;
        logic [7:0][31:0] ex_re;
        logic [7:0][31:0] ex_im;
        int               tol;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    ifft8 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .X0_real(Xr[0]), .X1_real(Xr[1]),
        .X2_real(Xr[2]), .X3_real(Xr[3]),
        .X4_real(Xr[4]), .X5_real(Xr[5]),
        .X6_real(Xr[6]), .X7_real(Xr[7]),
        .X0_imag(Xi[0]), .X1_imag(Xi[1]),
        .X2_imag(Xi[2]), .X3_imag(Xi[3]),
        .X4_imag(Xi[4]), .X5_imag(Xi[5]),
        .X6_imag(Xi[6]), .X7_imag(Xi[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0_real(xr[0]), .x1_real(xr[1]),
        .x2_real(xr[2]), .x3_real(xr[3]),
        .x4_real(xr[4]), .x5_real(xr[5]),
        .x6_real(xr[6]), .x7_real(xr[7]),
        .x0_imag(xi[0]), .x1_imag(xi[1]),
        .x2_imag(xi[2]), .x3_imag(xi[3]),
        .x4_imag(xi[4]), .x5_imag(xi[5]),
        .x6_imag(xi[6]), .x7_imag(xi[7]),
        .busy(busy)
    );

    task automatic chk_eq(input string nm, input logic [31:0] act,
                          input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_near(input string nm, input logic [31:0] act,
                            input real exp, input real tol);
        real d;
        checks++;
        d = real'($signed(act)) - exp;
        if (d > tol + 1e-6 || d < -tol - 1e-6) begin
            failures++;
            $display("FAIL %s: got %0d want %f (+-%0.1f)",
                     nm, $signed(act), exp, tol);
        end
    endtask

    // x[n] = 1/8 * sum X[k] e^{+j*2*pi*n*k/8}, with the 45-degree
    // cosine taken as the hardware's Q1.15 constant
    task automatic run_model();
        real cq, ang, wr, wi, ar, ai;
        int  m;
        cq = 23170.0 / 32768.0;
        for (int n = 0; n < 8; n++) begin
            mr[n] = 0.0;
            mi[n] = 0.0;
            for (int k = 0; k < 8; k++) begin
                m   = (n * k) % 8;
                ang = 2.0 * 3.14159265358979 * real'(m) / 8.0;
                wr  = $cos(ang);
                wi  = $sin(ang);
                if (m % 2 == 1) begin
                    wr = (wr > 0.0) ? cq : -cq;
                    wi = (wi > 0.0) ? cq : -cq;
                end
                ar = real'($signed(Xr[k]));
                ai = real'($signed(Xi[k]));
                mr[n] = mr[n] + ar * wr - ai * wi;
                mi[n] = mi[n] + ar * wi + ai * wr;
            end
            mr[n] = mr[n] / 8.0;
            mi[n] = mi[n] / 8.0;
        end
    endtask

    task automatic send_frame(output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_eq({nm, " ack out_valid"}, 32'(out_valid), 32'd0);
        chk_eq({nm, " ack in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic load_tbl(input int t);
        for (int k = 0; k < 8; k++) begin
            Xr[k] = tbl[t].in_re[k];
            Xi[k] = tbl[t].in_im[k];
        end
    endtask

    task automatic cmp_tbl(input int t);
        for (int k = 0; k < 8; k++) begin
            if (tbl[t].tol == 0) begin
                chk_eq($sformatf("v%0d x%0d_re", t, k), xr[k],
                       tbl[t].ex_re[k]);
                chk_eq($sformatf("v%0d x%0d_im", t, k), xi[k],
                       tbl[t].ex_im[k]);
            end else begin
                chk_near($sformatf("v%0d x%0d_re", t, k), xr[k],
                         real'($signed(tbl[t].ex_re[k])),
                         real'(tbl[t].tol));
                chk_near($sformatf("v%0d x%0d_im", t, k), xi[k],
                         real'($signed(tbl[t].ex_im[k])),
                         real'(tbl[t].tol));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  spurious;
        int  t;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            Xr[k] = '0;
            Xi[k] = '0;
        end

        for (int v = 0; v < 6; v++) tbl[v] = '0;
        tbl[0].in_re[0] = 32'h0008_0000;
        for (int k = 0; k < 8; k++) tbl[0].ex_re[k] = 32'h0001_0000;
        for (int k = 0; k < 8; k++) tbl[1].in_re[k] = 32'h0001_0000;
        tbl[1].ex_re[0] = 32'h0001_0000;
        tbl[2].in_re[1] = 32'h0008_0000;
        tbl[2].tol = 2;
        tbl[2].ex_re = {32'd46341, 32'd0, -32'd46341, -32'd65536,
                        -32'd46341, 32'd0, 32'd46341, 32'd65536};
        tbl[2].ex_im = {-32'd46341, -32'd65536, -32'd46341, 32'd0,
                        32'd46341, 32'd65536, 32'd46341, 32'd0};
        for (int k = 0; k < 8; k++) tbl[3].in_re[k] = 32'h7FFF_FFFF;
        tbl[3].ex_re[0] = 32'h7FFF_FFFF;
        tbl[4].in_im[0] = 32'h0008_0000;
        for (int k = 0; k < 8; k++) tbl[4].ex_im[k] = 32'h0001_0000;
        tbl[5].in_re[2] = 32'h0008_0000;
        tbl[5].ex_re = {32'd0, -32'd65536, 32'd0, 32'd65536,
                        32'd0, -32'd65536, 32'd0, 32'd65536};
        tbl[5].ex_im = {-32'd65536, 32'd0, 32'd65536, 32'd0,
                        -32'd65536, 32'd0, 32'd65536, 32'd0};

        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst in_ready", 32'(in_ready), 32'd1);
        chk_eq("rst out_valid", 32'(out_valid), 32'd0);
        chk_eq("rst busy", 32'(busy), 32'd0);
        chk_eq("rst x0_re", xr[0], 32'd0);
        chk_eq("rst x7_im", xi[7], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            load_tbl(v);
            send_frame(lat);
            chk_eq($sformatf("v%0d latency", v), 32'(lat), 32'd6);
            cmp_tbl(v);
            ack($sformatf("v%0d", v));
        end

        // backpressure: hold DONE, poke in_valid with other data
        load_tbl(0);
        send_frame(lat);
        chk_eq("bp latency", 32'(lat), 32'd6);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 3) begin
                load_tbl(3);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk_eq($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            chk_eq($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            chk_eq($sformatf("bp%0d x3_re", c), xr[3], 32'h0001_0000);
            chk_eq($sformatf("bp%0d x5_im", c), xi[5], 32'd0);
        end
        in_valid = 1'b0;
        ack("bp");
        repeat (3) @(negedge clk);
        chk_eq("bp no capture busy", 32'(busy), 32'd0);
        chk_eq("bp no capture ov", 32'(out_valid), 32'd0);
        chk_eq("bp x0_re kept", xr[0], 32'h0001_0000);

        // reset while the frame sits in TW_B
        load_tbl(2);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("tw_b busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("mid rst out_valid", 32'(out_valid), 32'd0);
        chk_eq("mid rst x0_re", xr[0], 32'd0);
        chk_eq("mid rst x4_re", xr[4], 32'd0);
        chk_eq("mid rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid || busy) spurious++;
        end
        chk_eq("post rst idle", 32'(spurious), 32'd0);
        load_tbl(1);
        send_frame(lat);
        chk_eq("post rst latency", 32'(lat), 32'd6);
        cmp_tbl(1);
        ack("post rst");

        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 8; k++) begin
                Xr[k] = 32'($signed($urandom) >>> 4);
                Xi[k] = 32'($signed($urandom) >>> 4);
            end
            if (r == 0) begin
                t = 0;
                for (int k = 0; k < 8; k++) Xi[k] = '0;
            end
            run_model();
            send_frame(lat);
            chk_eq($sformatf("rnd%0d latency", r), 32'(lat), 32'd6);
            for (int k = 0; k < 8; k++) begin
                chk_near($sformatf("rnd%0d x%0d_re", r, k), xr[k],
                         mr[k], 2.0);
                chk_near($sformatf("rnd%0d x%0d_im", r, k), xi[k],
                         mi[k], 2.0);
            end
            ack($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
